// File: rtl/axis_acc_serializer_if.sv
// axis_acc_serializer_if: AXI-Stream bundle (tvalid/tready/tdata/tuser/tlast).
// Ports (signals): tvalid, tready, tdata[DW], tuser[UW], tlast.
// The master modport drives the payload and valid, and the slave modport drives ready.
interface axis_acc_serializer_if #(
    parameter int DW = 8,
    parameter int UW = 1
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tlast;
    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_acc_serializer.sv
// axis_acc_serializer: requantize a COLS x ROWS accumulator beat and emit it one column per beat.
// Ports: aclk (clock), areset (async active-high reset),
//        s_axis (slave: COLS*ROWS*WORD_WIDTH_ACC accumulators, tuser, tlast),
//        m_axis (master: ROWS*WORD_WIDTH_OUT requantized column, held tuser, tlast on final column).
module axis_acc_serializer #(
    parameter int COLS           = 4,
    parameter int ROWS           = 2,
    parameter int WORD_WIDTH_ACC = 32,
    parameter int WORD_WIDTH_OUT = 8,
    parameter int SHIFT          = 4,
    parameter int TUSER_WIDTH    = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_acc_serializer_if.slave   s_axis,
    axis_acc_serializer_if.master  m_axis
);
    localparam int WA = WORD_WIDTH_ACC;
    localparam int WO = WORD_WIDTH_OUT;
    localparam int DW = COLS * ROWS * WA;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam logic signed [WA:0] ONE     = {{WA{1'b0}}, 1'b1};
    localparam logic signed [WA:0] RND     = SHIFT == 0 ? '0 : ONE << (SHIFT > 0 ? SHIFT - 1 : 0);
    localparam logic signed [WA:0] SAT_MAX = (ONE << (WO - 1)) - ONE;
    localparam logic signed [WA:0] SAT_MIN = -SAT_MAX - ONE;

    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          col_q, col_d;
    logic [DW-1:0]          data_q, data_d;
    logic [TUSER_WIDTH-1:0] user_q, user_d;
    logic                   last_q, last_d;
    logic                   last_col, s_hs, m_hs;
    logic [ROWS*WO-1:0]     tdata;

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [WO-1:0] requant(input logic signed [WA-1:0] x);
        logic signed [WA:0] y;
        y = ($signed({x[WA-1], x}) + RND) >>> SHIFT;
        return y > SAT_MAX ? {1'b0, {(WO-1){1'b1}}} :
               y < SAT_MIN ? {1'b1, {(WO-1){1'b0}}} : y[WO-1:0];
    endfunction

    assign last_col = col_q == CW'(COLS - 1);
    // Ready looks through to downstream ready on the final column so a new beat swaps in with no bubble.
    assign s_axis.tready = state_q == IDLE || (last_col && m_axis.tready);
    assign s_hs = s_axis.tvalid && s_axis.tready;
    assign m_hs = m_axis.tvalid && m_axis.tready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;
        if (s_hs) begin
            state_d = SEND;
            col_d   = '0;
            data_d  = s_axis.tdata;
            user_d  = s_axis.tuser;
            last_d  = s_axis.tlast;
        end else if (m_hs) begin
            state_d = last_col ? IDLE : SEND;
            col_d   = last_col ? '0 : col_q + CW'(1);
        end
    end

    always_comb begin
        tdata = '0;
        for (int r = 0; r < ROWS; r++)
            tdata[r*WO +: WO] = requant(data_q[(int'(col_q) * ROWS + r) * WA +: WA]);
    end

    assign m_axis.tvalid = state_q == SEND;
    assign m_axis.tdata  = tdata;
    assign m_axis.tuser  = user_q;
    assign m_axis.tlast  = last_q && last_col;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            col_q   <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: doc/axis_acc_serializer.md
# axis_acc_serializer

Serializes the wide accumulator beat from the convolution engine's output skid buffer into one column per beat. Each input beat carries COLS×ROWS signed accumulators. The block requantizes each accumulator (rounding right shift, then signed saturation) and emits COLS output beats of ROWS words each, column 0 first. It sits directly downstream of the conv engine's AXIS register and feeds the output packing/DMA path.

## Interface
- COLS, 4: columns per input beat; output beats per input beat.
- ROWS, 2: words per output beat.
- WORD_WIDTH_ACC, 32: signed input accumulator width.
- WORD_WIDTH_OUT, 8: signed output word width, must be ≤ WORD_WIDTH_ACC.
- SHIFT, 4: arithmetic right shift applied before saturation; range 0..WORD_WIDTH_ACC-1.
- TUSER_WIDTH, 8: sideband width, passed through unchanged.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  reset, asynchronous, active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tdata  in  COLS*ROWS*WORD_WIDTH_ACC  packed [COLS][ROWS] accumulators; element [c][r] at bit offset (c*ROWS+r)*WORD_WIDTH_ACC.
- s_axis_tuser  in  TUSER_WIDTH  sideband.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  ROWS*WORD_WIDTH_OUT  one column; row r at bit offset r*WORD_WIDTH_OUT.
- m_axis_tuser  out  TUSER_WIDTH  captured s_axis_tuser, held for all COLS beats.
- m_axis_tlast  out  1  captured tlast AND (col == COLS-1).

## Operation
- Holding register: data, user and last of one input beat. Column counter col spans 0..COLS-1. State bit full.
- States:
  - IDLE (full=0): s_axis_tready=1. On s handshake, capture the beat, set col=0, go to SEND.
  - SEND (full=1): m_axis_tvalid=1.
    - On m handshake with col<COLS-1: col increments.
    - On m handshake with col==COLS-1: if an s handshake occurs in the same cycle, capture the new beat, set col=0 and stay in SEND. Otherwise go to IDLE.
- s_axis_tready = !full || (col==COLS-1 && m_axis_tready). This is combinational from m_axis_tready; it gives zero-bubble back-to-back operation.
- Requantization per word, combinational from the holding register through the col mux:
  - y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at WORD_WIDTH_ACC+1 bits. With SHIFT=0 there is no add.
  - If y > 2^(WORD_WIDTH_OUT-1)-1, output the max. If y < -2^(WORD_WIDTH_OUT-1), output the min. Otherwise output y truncated.
- With m_axis_tvalid high, tdata, tuser and tlast stay stable until the handshake.
- tuser and tlast pass through with no interpretation.

## Timing
- Reset (async assert; release on aclk): full=0, col=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, s_axis_tready=1.
- Latency: s handshake at edge N gives column 0 valid after edge N. Column c is presented no earlier than cycle N+c.
- Throughput: one input beat per COLS cycles when m_axis_tready is held at 1. There is no idle cycle between input beats.
- Backpressure: with m_axis_tready=0, col holds and s_axis_tready=0 while full.
- Simultaneous final-column output and new input: both handshakes complete in the same cycle. The new beat's column 0 appears the next cycle.
- Reset mid-packet: the held beat is discarded and m_axis_tvalid drops immediately on assert. The first beat after release starts at col=0.
- COLS=1: every beat is a last column. Operation reduces to a one-stage register with pass-through ready.

## Test plan
All scenarios use COLS=4, ROWS=2, SHIFT=4, WORD_WIDTH_OUT=8.

- Rounding: accumulators 24, -24, 7, 8 in column 0 rows 0/1 and column 1 rows 0/1 -> outputs 0x02, 0xFF, 0x00, 0x01.
- Saturation: 0x00007FFF and 0xFFFF0000 -> 0x7F and 0x80. The value 2032 (0x7F0) -> 0x7F; 2040 -> rounds to 128 -> 0x7F.
- Streaming: 3 beats with tlast on the third, m_axis_tready=1 constantly.
  - Exactly 12 output beats on consecutive cycles, columns 0,1,2,3 repeating.
  - m_axis_tlast only on beat 12. tuser matches the source beat on all 4 columns.
- Backpressure: m_axis_tready random at 30% high.
  - Output sequence is identical to the streaming case.
  - No beat changes while tvalid=1 && tready=0.
  - s_axis_tready is never 1 while col<3 and full.
- Reset mid-packet: assert areset after column 1 is accepted.
  - m_axis_tvalid goes 0 asynchronously.
  - After release, a new beat yields columns 0..3 of the new data only.
- Same-cycle swap: hold s_axis_tvalid=1 with m_axis_tready=1.
  - s handshake occurs exactly on cycles where col==3.
  - No gap cycles in m_axis_tvalid.
